_penc32: RTL and testbench

Registered 32-to-5 priority encoder with pending-request latch and valid/ack handshake. It is the inverse of the 5-to-32 select decoder. It collects up to 32 request lines, such as interrupt or bus-request sources, into a pending register. It presents the index of the winning pending request to a single consumer, for example the trap/CSR logic of the core. The consumer's acknowledge clears that request and advances to the next one.

---
 rtl/_penc32_if.sv | 21 ++
 rtl/_penc32.sv | 66 ++++++
 tb/tb__penc32.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/_penc32_if.sv
// Request/grant bundle for the 32-to-5 priority encoder.
// The master is the request/consumer side; the slave is the encoder itself.
interface _penc32_if;
   logic [31:0] req;
   logic [31:0] mask;
   logic        flush;
   logic        ack;
   logic        valid;
   logic [4:0]  idx;
   logic [31:0] pend;

   modport master (
      output req, mask, flush, ack,
      input  valid, idx, pend
   );

   modport slave (
      input  req, mask, flush, ack,
      output valid, idx, pend
   );
endinterface

// File: rtl/_penc32.sv
// Registered 32-to-5 priority encoder.
// Requests collect in a pending latch; the winner is presented with a valid/ack handshake.
module _penc32 #(
   parameter bit HI_FIRST = 1'b1
) (
   input  logic     clk,
   input  logic     rst_n,
   _penc32_if.slave bus
);

   logic [31:0] pending;
   logic [31:0] pending_next;
   logic [31:0] clr;
   logic [31:0] cand;
   logic [4:0]  winner;
   logic        valid_q;
   logic [4:0]  idx_q;
   logic        load;

   // Set wins over clear, so a request in the ack cycle re-pends the granted bit.
   always_comb begin
      clr = '0;
      if (valid_q && bus.ack) begin
         clr = 32'd1 << idx_q;
      end
      pending_next = bus.flush ? '0 : ((pending & ~clr) | bus.req);
      cand         = pending_next & bus.mask;
   end

   always_comb begin
      winner = '0;
      if (HI_FIRST) begin
         for (int i = 0; i < 32; i++) begin
            if (cand[i]) winner = 5'(i);
         end
      end else begin
         for (int i = 31; i >= 0; i--) begin
            if (cand[i]) winner = 5'(i);
         end
      end
   end

   assign load = !valid_q || bus.ack;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pending <= '0;
         valid_q <= 1'b0;
         idx_q   <= '0;
      end else begin
         pending <= pending_next;
         if (bus.flush) begin
            valid_q <= 1'b0;
            idx_q   <= '0;
         end else if (load) begin
            valid_q <= |cand;
            idx_q   <= (|cand) ? winner : 5'd0;
         end
      end
   end

   assign bus.valid = valid_q;
   assign bus.idx   = idx_q;
   assign bus.pend  = pending;

endmodule

// File: tb/tb__penc32.sv
// Directed self-checking bench for _penc32: one instance per priority order,
// both driven by the same stimulus.
module tb__penc32;

   logic        clk;
   logic        rst_n;
   logic [31:0] req;
   logic [31:0] mask;
   logic        flush;
   logic        ack;
   int          checks;
   int          passed;

   _penc32_if hi_if ();
   _penc32_if lo_if ();

   assign hi_if.req   = req;
   assign hi_if.mask  = mask;
   assign hi_if.flush = flush;
   assign hi_if.ack   = ack;
   assign lo_if.req   = req;
   assign lo_if.mask  = mask;
   assign lo_if.flush = flush;
   assign lo_if.ack   = ack;

   _penc32 #(.HI_FIRST(1'b1)) dut_hi (.clk(clk), .rst_n(rst_n), .bus(hi_if.slave));
   _penc32 #(.HI_FIRST(1'b0)) dut_lo (.clk(clk), .rst_n(rst_n), .bus(lo_if.slave));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected) passed++;
      else $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
   endtask

   task automatic applyStimulus(input logic [31:0] r, input logic [31:0] m, input logic f, input logic a);
      req   = r;
      mask  = m;
      flush = f;
      ack   = a;
   endtask

   // One rising edge, then settle before sampling.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic checkHi(input string tag, input logic v, input logic [4:0] i, input logic [31:0] p);
      checkOutput({tag, ".hi.valid"}, 32'(hi_if.valid), 32'(v));
      checkOutput({tag, ".hi.idx"},   32'(hi_if.idx),   32'(i));
      checkOutput({tag, ".hi.pend"},  hi_if.pend,       p);
   endtask

   task automatic checkLo(input string tag, input logic v, input logic [4:0] i, input logic [31:0] p);
      checkOutput({tag, ".lo.valid"}, 32'(lo_if.valid), 32'(v));
      checkOutput({tag, ".lo.idx"},   32'(lo_if.idx),   32'(i));
      checkOutput({tag, ".lo.pend"},  lo_if.pend,       p);
   endtask

   initial begin
      checks = 0;
      passed = 0;
      rst_n  = 1'b0;
      applyStimulus(32'h0, 32'hFFFF_FFFF, 1'b0, 1'b0);
      #1;
      checkHi("por", 1'b0, 5'd0, 32'h0);
      #7 rst_n = 1'b1;

      // Fill everything, then assert reset mid-cycle.
      applyStimulus(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0);
      tick();
      checkHi("fill", 1'b1, 5'd31, 32'hFFFF_FFFF);
      checkLo("fill", 1'b1, 5'd0,  32'hFFFF_FFFF);
      applyStimulus(32'h0, 32'hFFFF_FFFF, 1'b0, 1'b0);
      #2 rst_n = 1'b0;
      #1;
      checkHi("async_rst", 1'b0, 5'd0, 32'h0);
      rst_n = 1'b1;
      tick();
      checkHi("post_rst", 1'b0, 5'd0, 32'h0);

      // Priority and drain with continuous ack.
      applyStimulus(32'h8000_0005, 32'hFFFF_FFFF, 1'b0, 1'b1);
      tick();
      checkHi("drain0", 1'b1, 5'd31, 32'h8000_0005);
      checkLo("drain0", 1'b1, 5'd0,  32'h8000_0005);
      applyStimulus(32'h0, 32'hFFFF_FFFF, 1'b0, 1'b1);
      tick();
      checkHi("drain1", 1'b1, 5'd2, 32'h0000_0005);
      checkLo("drain1", 1'b1, 5'd2, 32'h8000_0004);
      tick();
      checkHi("drain2", 1'b1, 5'd0,  32'h0000_0001);
      checkLo("drain2", 1'b1, 5'd31, 32'h8000_0000);
      tick();
      checkHi("drain3", 1'b0, 5'd0, 32'h0);
      checkLo("drain3", 1'b0, 5'd0, 32'h0);

      // Presented index holds against a higher request and a dropped mask.
      applyStimulus(32'h0000_0008, 32'hFFFF_FFFF, 1'b0, 1'b0);
      tick();
      checkHi("hold0", 1'b1, 5'd3, 32'h0000_0008);
      applyStimulus(32'h0010_0000, 32'hFFFF_FFF7, 1'b0, 1'b0);
      tick();
      checkHi("hold1", 1'b1, 5'd3, 32'h0010_0008);
      applyStimulus(32'h0, 32'hFFFF_FFF7, 1'b0, 1'b0);
      tick();
      checkHi("hold2", 1'b1, 5'd3, 32'h0010_0008);
      applyStimulus(32'h0, 32'hFFFF_FFF7, 1'b0, 1'b1);
      tick();
      checkHi("hold3", 1'b1, 5'd20, 32'h0010_0000);
      applyStimulus(32'h0, 32'hFFFF_FFFF, 1'b0, 1'b1);
      tick();
      checkHi("hold4", 1'b0, 5'd0, 32'h0);

      // Set wins over clear on the granted bit.
      applyStimulus(32'h0000_0080, 32'hFFFF_FFFF, 1'b0, 1'b0);
      tick();
      checkHi("swc0", 1'b1, 5'd7, 32'h0000_0080);
      applyStimulus(32'h0000_0A80, 32'hFFFF_FFFF, 1'b0, 1'b1);
      tick();
      checkHi("swc1", 1'b1, 5'd11, 32'h0000_0A80);
      applyStimulus(32'h0, 32'hFFFF_FFFF, 1'b0, 1'b1);
      tick();
      checkHi("swc2", 1'b1, 5'd9, 32'h0000_0280);
      tick();
      checkHi("swc3", 1'b1, 5'd7, 32'h0000_0080);
      tick();
      checkHi("swc4", 1'b0, 5'd0, 32'h0);

      // Masked request latches but is not selected until unmasked.
      applyStimulus(32'h0000_0010, 32'hFFFF_FFEF, 1'b0, 1'b0);
      tick();
      checkHi("mask0", 1'b0, 5'd0, 32'h0000_0010);
      applyStimulus(32'h0, 32'hFFFF_FFFF, 1'b0, 1'b0);
      tick();
      checkHi("mask1", 1'b1, 5'd4, 32'h0000_0010);
      checkLo("mask1", 1'b1, 5'd4, 32'h0000_0010);
      applyStimulus(32'h0, 32'hFFFF_FFFF, 1'b0, 1'b1);
      tick();
      checkHi("mask2", 1'b0, 5'd0, 32'h0);

      // Flush beats ack and a same-cycle request.
      applyStimulus(32'h0000_00F0, 32'hFFFF_FFFF, 1'b0, 1'b0);
      tick();
      checkHi("flush0", 1'b1, 5'd7, 32'h0000_00F0);
      applyStimulus(32'h0000_0002, 32'hFFFF_FFFF, 1'b1, 1'b1);
      tick();
      checkHi("flush1", 1'b0, 5'd0, 32'h0);
      checkLo("flush1", 1'b0, 5'd0, 32'h0);
      applyStimulus(32'h0, 32'hFFFF_FFFF, 1'b0, 1'b1);
      tick();
      checkHi("flush2", 1'b0, 5'd0, 32'h0);

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
